// File: rtl/axis_arb_pkg.sv
// Shared types for the packet-aware AXI-Stream round-robin arbiter.
package axis_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
    localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: the first requester after 'last', wrapping modulo N.
module rr_priority_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        // Walk from the farthest slot to the nearest so the nearest requester is the last write.
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Shares one AXI-Stream sink among NUM_SRC masters; the grant is held from the first beat to TLast.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_SRC*WIDTH-1:0] S_TData,
    input  logic [NUM_SRC-1:0]       S_TValid,
    input  logic [NUM_SRC-1:0]       S_TLast,
    output logic [NUM_SRC-1:0]       S_TReady,
    output logic [WIDTH-1:0]         M_TData,
    output logic                     M_TValid,
    output logic                     M_TLast,
    input  logic                     M_TReady,
    output logic [IDX_W-1:0]         GrantIdx,
    output logic                     isBusy,
    output logic [PKT_CNT_W-1:0]     PktCount
);
    arb_state_t                    state, state_nxt;
    logic [IDX_W-1:0]              last_grant, pick_idx;
    logic                          pick_any, pkt_done;
    logic [NUM_SRC-1:0][WIDTH-1:0] src_data;

    assign src_data = S_TData;
    assign isBusy   = (state == ARB_LOCKED);

    rr_priority_pick #(.N(NUM_SRC)) u_pick (
        .req  (S_TValid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Ready toward the sources depends only on the registered grant, never on S_TValid.
    always_comb begin
        state_nxt = state;
        M_TData   = src_data[GrantIdx];
        M_TValid  = 1'b0;
        M_TLast   = 1'b0;
        S_TReady  = '0;
        pkt_done  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nxt = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                M_TValid           = S_TValid[GrantIdx];
                M_TLast            = S_TLast[GrantIdx];
                S_TReady[GrantIdx] = M_TReady;
                pkt_done           = M_TValid && M_TReady && M_TLast;
                if (pkt_done) state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ARB_IDLE;
            GrantIdx   <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            PktCount   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_any) GrantIdx <= pick_idx;
            if (pkt_done) begin
                last_grant <= GrantIdx;
                PktCount   <= PktCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench: per-source beat queues feed the arbiter, a ready-driven sink logs accepted beats.
module tb_axis_rr_packet_arbiter;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] S_TData;
    logic [3:0]  S_TValid, S_TLast, S_TReady;
    logic [7:0]  M_TData;
    logic        M_TValid, M_TLast, M_TReady;
    logic [1:0]  GrantIdx;
    logic        isBusy;
    logic [15:0] PktCount;

    axis_rr_packet_arbiter #(.NUM_SRC(4), .WIDTH(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .S_TData(S_TData), .S_TValid(S_TValid), .S_TLast(S_TLast), .S_TReady(S_TReady),
        .M_TData(M_TData), .M_TValid(M_TValid), .M_TLast(M_TLast), .M_TReady(M_TReady),
        .GrantIdx(GrantIdx), .isBusy(isBusy), .PktCount(PktCount)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  src_mem [4][16];
    int          hd [4];
    int          tl [4];
    bit  [3:0]   hold;
    logic [7:0]  log_d [64];
    logic        log_l [64];
    logic [1:0]  log_g [64];
    int          nlog;

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; end
        hold = '0;
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic last);
        src_mem[s][tl[s]] = {last, d};
        tl[s]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < 4; i++) if (hd[i] < tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            S_TValid[i]      = (hd[i] < tl[i]) && !hold[i];
            S_TData[i*8 +: 8] = src_mem[i][hd[i]][7:0];
            S_TLast[i]       = src_mem[i][hd[i]][8];
        end
    endtask

    // One clock: settle inputs, record handshakes seen before the edge, clock, re-drive.
    task automatic step();
        drive_srcs();
        #1;
        if (M_TValid && M_TReady) begin
            log_d[nlog] = M_TData; log_l[nlog] = M_TLast; log_g[nlog] = GrantIdx;
            nlog++;
        end
        for (int i = 0; i < 4; i++) if (S_TValid[i] && S_TReady[i]) hd[i]++;
        @(posedge CLK);
        #1;
        drive_srcs();
        #1;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while ((pending() || isBusy) && c < 60) begin step(); c++; end
        n_cmp++;
        if (pending() || isBusy) begin
            n_err++; $display("FAIL %s_timeout: still busy/pending after %0d cycles, want drained", tag, c);
        end
    endtask

    task automatic test_reset();
        clear_srcs();
        for (int i = 0; i < 4; i++) push(i, 8'(8'hF0 + i), 1'b1);
        Reset = 1'b1;
        step(); step();
        n_cmp++; if (M_TValid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid: got %b want 0", M_TValid); end
        n_cmp++; if (S_TReady !== 4'b0) begin n_err++; $display("FAIL reset_sready: got %b want 0000", S_TReady); end
        n_cmp++; if (PktCount !== 16'd0) begin n_err++; $display("FAIL reset_pktcount: got %0d want 0", PktCount); end
        n_cmp++; if (isBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", isBusy); end
        n_cmp++; if (GrantIdx !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", GrantIdx); end
        clear_srcs();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
        logic       el [3] = '{1'b0, 1'b0, 1'b1};
        clear_srcs(); nlog = 0;
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        step();
        n_cmp++; if (GrantIdx !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", GrantIdx); end
        n_cmp++; if (isBusy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", isBusy); end
        n_cmp++; if (M_TValid !== 1'b1 || M_TData !== 8'h11) begin
            n_err++; $display("FAIL single_first: got v=%b d=%h want v=1 d=11", M_TValid, M_TData); end
        n_cmp++; if (S_TReady !== 4'b0100) begin n_err++; $display("FAIL single_sready: got %b want 0100", S_TReady); end
        drain("single");
        n_cmp++; if (nlog !== 3) begin n_err++; $display("FAIL single_nbeats: got %0d want 3", nlog); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (log_d[k] !== ed[k] || log_l[k] !== el[k] || log_g[k] !== 2'd2) begin
                n_err++; $display("FAIL single_beat%0d: got d=%h l=%b g=%0d want d=%h l=%b g=2",
                                  k, log_d[k], log_l[k], log_g[k], ed[k], el[k]);
            end
        end
        n_cmp++; if (PktCount !== 16'd1) begin n_err++; $display("FAIL single_pktcount: got %0d want 1", PktCount); end
        n_cmp++; if (isBusy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b want 0", isBusy); end
    endtask

    task automatic test_mid_idle();
        logic [7:0] ed [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        logic       el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] eg [4] = '{2'd1, 2'd1, 2'd1, 2'd3};
        clear_srcs(); nlog = 0;
        push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b1);
        step();
        n_cmp++; if (GrantIdx !== 2'd1) begin n_err++; $display("FAIL idle_grant: got %0d want 1", GrantIdx); end
        push(3, 8'hB0, 1'b1);
        step();
        hold[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (GrantIdx !== 2'd1 || M_TValid !== 1'b0 || S_TReady[3] !== 1'b0) begin
                n_err++; $display("FAIL idle_hold%0d: got g=%0d v=%b rdy3=%b want g=1 v=0 rdy3=0",
                                  c, GrantIdx, M_TValid, S_TReady[3]);
            end
        end
        hold[1] = 1'b0;
        drain("idle");
        n_cmp++; if (nlog !== 4) begin n_err++; $display("FAIL idle_nbeats: got %0d want 4", nlog); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (log_d[k] !== ed[k] || log_l[k] !== el[k] || log_g[k] !== eg[k]) begin
                n_err++; $display("FAIL idle_beat%0d: got d=%h l=%b g=%0d want d=%h l=%b g=%0d",
                                  k, log_d[k], log_l[k], log_g[k], ed[k], el[k], eg[k]);
            end
        end
        n_cmp++; if (PktCount !== 16'd3) begin n_err++; $display("FAIL idle_pktcount: got %0d want 3", PktCount); end
    endtask

    task automatic test_fairness();
        logic [7:0] ed [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
        logic [1:0] eg [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        int cyc = 0;
        clear_srcs(); nlog = 0;
        for (int i = 0; i < 4; i++) begin
            push(i, 8'(i * 16), 1'b0); push(i, 8'(i * 16 + 1), 1'b1);
        end
        push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1);
        while ((pending() || isBusy) && cyc < 40) begin step(); cyc++; end
        // 5 packets x (1 arbitration bubble + 2 beats)
        n_cmp++; if (cyc !== 15) begin n_err++; $display("FAIL fair_cycles: got %0d want 15", cyc); end
        n_cmp++; if (nlog !== 10) begin n_err++; $display("FAIL fair_nbeats: got %0d want 10", nlog); end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (log_d[k] !== ed[k] || log_l[k] !== 1'(k % 2) || log_g[k] !== eg[k]) begin
                n_err++; $display("FAIL fair_beat%0d: got d=%h l=%b g=%0d want d=%h l=%0d g=%0d",
                                  k, log_d[k], log_l[k], log_g[k], ed[k], k % 2, eg[k]);
            end
        end
        n_cmp++; if (PktCount !== 16'd8) begin n_err++; $display("FAIL fair_pktcount: got %0d want 8", PktCount); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ed [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        clear_srcs(); nlog = 0;
        for (int k = 0; k < 4; k++) push(2, ed[k], k == 3);
        step(); step(); step();
        M_TReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (M_TData !== 8'hC2 || M_TValid !== 1'b1 || GrantIdx !== 2'd2 || S_TReady !== 4'b0) begin
                n_err++; $display("FAIL bp_stall%0d: got d=%h v=%b g=%0d rdy=%b want d=c2 v=1 g=2 rdy=0000",
                                  c, M_TData, M_TValid, GrantIdx, S_TReady);
            end
        end
        M_TReady = 1'b1;
        drain("bp");
        n_cmp++; if (nlog !== 4) begin n_err++; $display("FAIL bp_nbeats: got %0d want 4", nlog); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (log_d[k] !== ed[k] || log_l[k] !== (k == 3) || log_g[k] !== 2'd2) begin
                n_err++; $display("FAIL bp_beat%0d: got d=%h l=%b g=%0d want d=%h g=2",
                                  k, log_d[k], log_l[k], log_g[k], ed[k]);
            end
        end
        n_cmp++; if (PktCount !== 16'd9) begin n_err++; $display("FAIL bp_pktcount: got %0d want 9", PktCount); end
    endtask

    task automatic test_reset_mid();
        clear_srcs(); nlog = 0;
        for (int k = 0; k < 4; k++) push(0, 8'(8'hD0 + k), k == 3);
        step();
        n_cmp++; if (GrantIdx !== 2'd0) begin n_err++; $display("FAIL rmid_grant: got %0d want 0", GrantIdx); end
        step();
        Reset = 1'b1;
        step();
        n_cmp++;
        if (isBusy !== 1'b0 || M_TValid !== 1'b0 || S_TReady !== 4'b0 || PktCount !== 16'd0) begin
            n_err++; $display("FAIL rmid_reset: got busy=%b v=%b rdy=%b cnt=%0d want 0 0 0000 0",
                              isBusy, M_TValid, S_TReady, PktCount);
        end
        Reset = 1'b0;
        clear_srcs(); nlog = 0;
        push(1, 8'hF1, 1'b1); push(0, 8'hE0, 1'b1);
        step();
        n_cmp++; if (GrantIdx !== 2'd0) begin n_err++; $display("FAIL rmid_rearb: got %0d want 0", GrantIdx); end
        drain("rmid");
        n_cmp++;
        if (nlog !== 2 || log_d[0] !== 8'hE0 || log_g[0] !== 2'd0 || log_d[1] !== 8'hF1 || log_g[1] !== 2'd1) begin
            n_err++; $display("FAIL rmid_order: got n=%0d %h/g%0d %h/g%0d want 2 e0/g0 f1/g1",
                              nlog, log_d[0], log_g[0], log_d[1], log_g[1]);
        end
        n_cmp++; if (PktCount !== 16'd2) begin n_err++; $display("FAIL rmid_pktcount: got %0d want 2", PktCount); end
    endtask

    initial begin
        Reset = 1'b1; M_TReady = 1'b1; nlog = 0;
        S_TData = '0; S_TValid = '0; S_TLast = '0;
        clear_srcs();
        test_reset();
        test_single();
        test_mid_idle();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
